// File: rtl/wb_write_arbiter_pkg.sv
// Shared defaults and types for the writeback arbiter slice.
package wb_write_arbiter_pkg;

    // Default FIFO depth and starvation limit for the LSU/MUL path.
    localparam int WB_DEPTH      = 4;
    localparam int WB_STARVE_MAX = 8;

    // Register-address and data bus widths of the core.
    localparam int WB_AW = 5;
    localparam int WB_DW = 32;

    // Source loaded into the output stage in a given cycle.
    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_FIFO = 2'd2
    } wb_sel_e;

endpackage : wb_write_arbiter_pkg

// File: rtl/wb_write_arbiter_if.sv
// Result-producer handshakes and register-file write port of the arbiter.
interface wb_write_arbiter_if
    import wb_write_arbiter_pkg::*;
#(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
);
    logic              alu_valid;
    logic              alu_ready;
    logic [AW-1:0]     alu_waddr;
    logic [DW-1:0]     alu_wdata;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [AW-1:0]     lsu_waddr;
    logic [DW-1:0]     lsu_wdata;

    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;

    logic [(1<<AW)-1:0] busy_mask;
    logic              starve;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        output alu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata,
        output busy_mask, starve
    );

    // Producer / register-file side.
    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output lsu_valid, lsu_waddr, lsu_wdata,
        input  alu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        input  busy_mask, starve
    );

endinterface : wb_write_arbiter_if

// File: rtl/wb_sync_fifo.sv
// Strict-FIFO buffer for LSU/MUL writes; exposes every slot for busy tracking.
module wb_sync_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [AW-1:0]           push_waddr_i,
    input  logic [DW-1:0]           push_wdata_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [AW-1:0]           head_waddr_o,
    output logic [DW-1:0]           head_wdata_o,
    output logic [DEPTH-1:0]        ent_valid_o,
    output logic [DEPTH-1:0][AW-1:0] ent_waddr_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] waddr_mem_q [DEPTH];
    logic [DW-1:0] wdata_mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    // Full/empty come straight from the registered count, so a push while
    // full is refused even if the same cycle pops.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    assign head_waddr_o = waddr_mem_q[head_q];
    assign head_wdata_o = wdata_mem_q[head_q];

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) tail_d = tail_q + 1'b1;
        if (pop_ok)  head_d = head_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    // Pointer and count registers; reset discards everything queued.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage write on accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; slot validity comes from head/count alone.
        if (push_ok) begin
            waddr_mem_q[tail_q] <= push_waddr_i;
            wdata_mem_q[tail_q] <= push_wdata_i;
        end
    end

    // A slot is live when its distance from head is below the count.
    always_comb begin
        logic [PW-1:0] offset;
        ent_valid_o = '0;
        ent_waddr_o = '0;
        offset      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PW'(i) - head_q;
            ent_valid_o[i] = ({1'b0, offset} < count_q);
            ent_waddr_o[i] = waddr_mem_q[i];
        end
    end

endmodule : wb_sync_fifo

// File: rtl/wb_write_arbiter.sv
// Merges the ALU and buffered LSU/MUL results into one registered RF write.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX,
    parameter int AW         = WB_AW,
    parameter int DW         = WB_DW
) (
    input  logic               clk,
    input  logic               rst,
    wb_write_arbiter_if.slave  bus
);
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int NREG = 1 << AW;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [AW-1:0]            head_waddr;
    logic [DW-1:0]            head_wdata;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_waddr;

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          rf_wen_q, rf_wen_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;

    logic    starve;
    logic    alu_fire;
    logic    lsu_push;
    logic    fifo_pop;
    wb_sel_e sel;

    wb_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (lsu_push),
        .push_waddr_i (bus.lsu_waddr),
        .push_wdata_i (bus.lsu_wdata),
        .pop_i        (fifo_pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_waddr_o (head_waddr),
        .head_wdata_o (head_wdata),
        .ent_valid_o  (ent_valid),
        .ent_waddr_o  (ent_waddr)
    );

    // Back-pressure the ALU once the FIFO head has waited STARVE_MAX cycles.
    assign starve        = ~fifo_empty & (starve_cnt_q == SW'(STARVE_MAX));
    assign bus.starve    = starve;
    assign bus.alu_ready = ~starve;
    assign bus.lsu_ready = ~fifo_full;

    assign alu_fire = bus.alu_valid & ~starve;
    assign lsu_push = bus.lsu_valid & ~fifo_full;

    // Output-stage source: ALU first, then FIFO head, else idle.
    always_comb begin
        sel = SEL_IDLE;
        if (alu_fire)         sel = SEL_ALU;
        else if (!fifo_empty) sel = SEL_FIFO;
    end

    assign fifo_pop = (sel == SEL_FIFO);

    // Next output-stage contents; register 0 writes are swallowed here.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        unique case (sel)
            SEL_ALU: begin
                rf_wen_d   = (bus.alu_waddr != '0);
                rf_waddr_d = bus.alu_waddr;
                rf_wdata_d = bus.alu_wdata;
            end
            SEL_FIFO: begin
                rf_wen_d   = (head_waddr != '0);
                rf_waddr_d = head_waddr;
                rf_wdata_d = head_wdata;
            end
            default: ;
        endcase
    end

    // Starve counter: counts non-popping cycles with a waiting head, saturating.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || fifo_pop)            starve_cnt_d = '0;
        else if (starve_cnt_q != SW'(STARVE_MAX)) starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // Output stage and starve counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

    // Busy mask: every live FIFO slot plus a pending output write; r0 never busy.
    always_comb begin
        logic [NREG-1:0] mask;
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) mask[ent_waddr[i]] = 1'b1;
        end
        if (rf_wen_q) mask[rf_waddr_q] = 1'b1;
        mask[0] = 1'b0;
        bus.busy_mask = mask;
    end

endmodule : wb_write_arbiter

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter.
module tb_wb_write_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    wb_write_arbiter_if #(.AW(5), .DW(32)) bus ();

    wb_write_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (8),
        .AW         (5),
        .DW         (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_waddr = '0;
        bus.alu_wdata = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_waddr = '0;
        bus.lsu_wdata = '0;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_waddr = a;
        bus.alu_wdata = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lsu_valid = v;
        bus.lsu_waddr = a;
        bus.lsu_wdata = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst = 1'b0;
        #3;
        check("rst_wen",       32'(bus.rf_wen),    32'h0);
        check("rst_waddr",     32'(bus.rf_waddr),  32'h0);
        check("rst_wdata",     bus.rf_wdata,       32'h0);
        check("rst_busy",      bus.busy_mask,      32'h0);
        check("rst_lsu_ready", 32'(bus.lsu_ready), 32'h1);
        check("rst_alu_ready", 32'(bus.alu_ready), 32'h1);
        check("rst_starve",    32'(bus.starve),    32'h0);
        step();
        rst = 1'b1;
        step();

        // ALU only.
        drive_alu(1'b1, 5'd3, 32'hA5A5A5A5);
        #1 check("alu_ready", 32'(bus.alu_ready), 32'h1);
        step();
        idle();
        #1;
        check("alu_wen",   32'(bus.rf_wen),   32'h1);
        check("alu_waddr", 32'(bus.rf_waddr), 32'd3);
        check("alu_wdata", bus.rf_wdata,      32'hA5A5A5A5);
        check("alu_busy",  bus.busy_mask,     32'h8);
        step();
        check("alu_wen_off",  32'(bus.rf_wen), 32'h0);
        check("alu_busy_off", bus.busy_mask,   32'h0);

        // LSU only: two-cycle minimum latency, no bypass.
        drive_lsu(1'b1, 5'd7, 32'h12345678);
        #1 check("lsu_ready", 32'(bus.lsu_ready), 32'h1);
        step();
        idle();
        #1;
        check("lsu_c2_busy", bus.busy_mask,     32'h80);
        check("lsu_c2_wen",  32'(bus.rf_wen),   32'h0);
        step();
        check("lsu_c3_wen",   32'(bus.rf_wen),   32'h1);
        check("lsu_c3_waddr", 32'(bus.rf_waddr), 32'd7);
        check("lsu_c3_wdata", bus.rf_wdata,      32'h12345678);
        check("lsu_c3_busy",  bus.busy_mask,     32'h80);
        step();
        check("lsu_c4_busy", bus.busy_mask,   32'h0);
        check("lsu_c4_wen",  32'(bus.rf_wen), 32'h0);

        // Fill and back-pressure: ALU to r9 every cycle, LSU pushes r1..r5.
        drive_alu(1'b1, 5'd9, 32'h99);
        for (int k = 1; k <= 4; k++) begin
            drive_lsu(1'b1, 5'(k), 32'h100 + 32'(k));
            #1 check($sformatf("fill_ready_%0d", k), 32'(bus.lsu_ready), 32'h1);
            step();
        end
        // Cycle 5: FIFO holds r1..r4, output holds the ALU write to r9.
        drive_lsu(1'b1, 5'd5, 32'h105);
        #1;
        check("fill_full_ready", 32'(bus.lsu_ready), 32'h0);
        check("fill_busy",       bus.busy_mask,      32'h21E);
        for (int c = 5; c <= 9; c++) begin
            check($sformatf("fill_nostarve_c%0d", c), 32'(bus.starve), 32'h0);
            step();
        end
        // Cycle 10: head has waited 8 cycles.
        check("starve_on",        32'(bus.starve),    32'h1);
        check("starve_alu_ready", 32'(bus.alu_ready), 32'h0);
        check("starve_lsu_ready", 32'(bus.lsu_ready), 32'h0);
        step();
        // Cycle 11: r1 written, counter cleared, one slot free.
        check("starve_waddr",  32'(bus.rf_waddr),  32'd1);
        check("starve_wdata",  bus.rf_wdata,       32'h101);
        check("starve_wen",    32'(bus.rf_wen),    32'h1);
        check("starve_off",    32'(bus.starve),    32'h0);
        check("refill_ready",  32'(bus.lsu_ready), 32'h1);
        bus.alu_valid = 1'b0;
        step();
        bus.lsu_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            #1;
            check($sformatf("drain_waddr_%0d", k), 32'(bus.rf_waddr), 32'(k));
            check($sformatf("drain_wen_%0d", k),   32'(bus.rf_wen),   32'h1);
            step();
        end
        check("drain_done_wen",  32'(bus.rf_wen), 32'h0);
        check("drain_done_busy", bus.busy_mask,   32'h0);

        // Register 0 is accepted but never written or marked busy.
        drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        #1 check("r0_alu_ready", 32'(bus.alu_ready), 32'h1);
        step();
        idle();
        #1;
        check("r0_wen",  32'(bus.rf_wen), 32'h0);
        check("r0_busy", bus.busy_mask,   32'h0);
        step();

        // Simultaneous push and pop with two entries queued.
        drive_alu(1'b1, 5'd20, 32'h20);
        drive_lsu(1'b1, 5'd10, 32'hA0);
        step();
        drive_lsu(1'b1, 5'd11, 32'hB0);
        step();
        bus.alu_valid = 1'b0;
        drive_lsu(1'b1, 5'd12, 32'hC0);
        #1;
        check("sim_busy_pre",  bus.busy_mask,      32'h00100C00);
        check("sim_lsu_ready", 32'(bus.lsu_ready), 32'h1);
        step();
        idle();
        #1;
        check("sim_busy_post", bus.busy_mask, 32'h00001C00);
        for (int k = 10; k <= 12; k++) begin
            check($sformatf("sim_order_%0d", k), 32'(bus.rf_waddr), 32'(k));
            check($sformatf("sim_data_%0d", k),  bus.rf_wdata,      32'hA0 + 32'((k - 10) * 16));
            step();
        end
        check("sim_done_wen", 32'(bus.rf_wen), 32'h0);

        // Reset mid-operation with three writes queued.
        drive_alu(1'b1, 5'd21, 32'h21);
        for (int k = 13; k <= 15; k++) begin
            drive_lsu(1'b1, 5'(k), 32'(k));
            step();
        end
        rst = 1'b0;
        #1;
        check("mrst_wen",       32'(bus.rf_wen),    32'h0);
        check("mrst_busy",      bus.busy_mask,      32'h0);
        check("mrst_lsu_ready", 32'(bus.lsu_ready), 32'h1);
        idle();
        step();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("mrst_quiet_%0d", c), 32'(bus.rf_wen), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_write_arbiter

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Writeback-side arbiter that drives the single write port of the 32-entry register file.
- It merges two result producers into one registered write stream: the single-cycle ALU path and the variable-latency LSU/MUL path.
- The LSU/MUL path is buffered in a small FIFO.
- It exports a busy mask so issue logic can stall on registers with a write still in flight.

Parameters:
DEPTH, 4, LSU FIFO entries; power of two, at least 2
STARVE_MAX, 8, consecutive cycles the FIFO head may wait before the ALU is back-pressured
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU result offered this cycle
alu_ready  output  1  ALU result accepted when alu_valid & alu_ready
alu_waddr  input  AW  ALU destination register
alu_wdata  input  DW  ALU result
lsu_valid  input  1  LSU/MUL result offered
lsu_ready  output  1  LSU/MUL result accepted when lsu_valid & lsu_ready
lsu_waddr  input  AW  LSU/MUL destination register
lsu_wdata  input  DW  LSU/MUL result
rf_wen  output  1  register file write enable (registered)
rf_waddr  output  AW  register file write address (registered)
rf_wdata  output  DW  register file write data (registered)
busy_mask  output  32  bit i set while a write to register i is queued or in the output stage
starve  output  1  ALU back-pressure active this cycle (debug)

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied; head/tail pointers and count set to 0.
  - Starve counter set to 0.
  - rf_wen, rf_waddr, rf_wdata set to 0.
  - Any queued writes are discarded. Reset mid-operation loses them; this is intended.
- lsu_ready = (count != DEPTH).
  - Depends on registered count only.
  - A push while full is not accepted, even if the same cycle pops.
- starve = (count != 0) & (starve_cnt == STARVE_MAX).
- alu_ready = ~starve.
- Output-stage selection each cycle, in priority order:
  1. alu_valid & alu_ready: output loads the ALU write.
  2. Otherwise, count != 0: FIFO head pops into the output.
  3. Otherwise: rf_wen <= 0, and rf_waddr/rf_wdata hold their values.
- Latency:
  - ALU: accepted in cycle N, rf_wen in cycle N+1.
  - LSU/MUL: pushed in cycle N, rf_wen no earlier than N+2. There is no FIFO bypass.
- Register 0: a write with waddr == 0 is accepted and consumes its slot, but the output stage drives rf_wen = 0 for it.
- Starve counter:
  - Increments when count != 0 and the FIFO did not pop this cycle, saturating at STARVE_MAX.
  - Clears to 0 on every pop and whenever count == 0.
  - While starve is asserted, the FIFO pops that cycle, so the counter clears next cycle.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- Pointers wrap modulo DEPTH. count is a separate register, log2(DEPTH)+1 bits wide.
- busy_mask:
  - Combinational OR of one-hot(waddr) over all valid FIFO entries, plus the output stage when rf_wen = 1.
  - Bit 0 is always 0.
- Ordering:
  - The block never reorders or squashes writes.
  - Upstream issue must stall any instruction whose destination has its busy_mask bit set. WAW correctness is upstream's responsibility.
  - FIFO order is strict first-in, first-out.

Decomposition:
- Shared defines header gains:
  - WB_DEPTH, the default FIFO depth.
  - WB_STARVE_MAX, the default starvation limit.
  - The existing register-address and data bus width macros are reused for AW/DW.
- One sub-module is natural: wb_sync_fifo, holding the storage array, pointers and count.
  - Exposes push/pop/full/empty, the head entry, and per-entry valid plus waddr vectors for busy_mask generation.
- The arbiter, starve counter and output register stay in wb_write_arbiter.

Test Plan:
- ALU only: alu_valid=1, waddr=3, wdata=0xA5A5A5A5 in cycle 1 -> rf_wen=1, rf_waddr=3, rf_wdata=0xA5A5A5A5 in cycle 2; busy_mask=0x8 during cycle 2 only.
- LSU only: push waddr=7, data=0x12345678 in cycle 1, alu_valid=0 -> busy_mask bit 7 set from cycle 2; rf_wen for reg 7 in cycle 3; busy_mask=0 in cycle 4.
- Fill and back-pressure: alu_valid=1 continuously, 5 LSU pushes to regs 1..5 -> lsu_ready=0 after 4 accepted; starve asserts after 8 waiting cycles; alu_ready=0 that cycle; rf_waddr=1 written next cycle.
- Register 0: ALU write to reg 0 with data 0xFFFFFFFF -> alu_ready=1, rf_wen stays 0, busy_mask stays 0.
- Simultaneous events: FIFO holding 2 entries, alu_valid=0 and lsu_valid=1 in the same cycle -> one pop plus one push; count stays 2; writes emerge in push order.
- Reset mid-operation: 3 entries queued, rst low for 1 cycle -> rf_wen=0, busy_mask=0, lsu_ready=1 immediately; no queued write appears after release.
